// File: rtl/iir_y_f2i_pkg.sv
// iir_y_f2i shared types: float field layout, constants, FSM states.
// Float layout: sign [31], exp [30:23], frac [22:0].
package iir_y_f2i_pkg;

  localparam int         EXP_BIAS    = 127;
  localparam logic [7:0] EXP_SPECIAL = 8'hFF;

  typedef struct packed {
    logic        s;
    logic [7:0]  exp;
    logic [22:0] frac;
  } f32_t;

  typedef enum logic [4:0] {
    ST_IDLE   = 5'b00001,
    ST_DECODE = 5'b00010,
    ST_SHIFT  = 5'b00100,
    ST_SIGN   = 5'b01000,
    ST_FINISH = 5'b10000
  } state_e;

endpackage

// File: rtl/iir_y_f2i_if.sv
// iir_y_f2i handshake bundle: float in (VALID/ACK), integer out (VALID/ACK).
// slave = converter side, master = filter/packer side.
interface iir_y_f2i_if #(
  parameter int OUT_W = 24
);
  logic [31:0]      i_Y_DATA;
  logic             i_Y_DATA_VALID;
  logic             o_Y_ACK;
  logic [OUT_W-1:0] o_INT_DATA;
  logic             o_INT_DATA_VALID;
  logic             i_INT_ACK;

  modport slave (
    input  i_Y_DATA,
    input  i_Y_DATA_VALID,
    output o_Y_ACK,
    output o_INT_DATA,
    output o_INT_DATA_VALID,
    input  i_INT_ACK
  );

  modport master (
    output i_Y_DATA,
    output i_Y_DATA_VALID,
    input  o_Y_ACK,
    input  o_INT_DATA,
    input  o_INT_DATA_VALID,
    output i_INT_ACK
  );
endinterface

// File: rtl/iir_y_f2i_shifter.sv
// f2i_shifter: one-bit-per-cycle magnitude shifter with optional guard bit.
// Ports: i_load/i_sig/i_cnt/i_left start a run; o_busy, o_done, o_mag, o_guard.
// IIR_Y_F2I_ROUND_EN keeps the last right-shifted-out bit as o_guard.
module f2i_shifter #(
  parameter int OUT_W = 24
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_load,
  input  logic [23:0]      i_sig,
  input  logic [4:0]       i_cnt,
  input  logic             i_left,
  output logic             o_busy,
  output logic             o_done,
  output logic [OUT_W-1:0] o_mag,
  output logic             o_guard
);
  localparam int MAG_W = OUT_W + 25;

  logic [MAG_W-1:0] r_mag;
  logic [4:0]       r_cnt;
  logic             r_left;
  logic             r_busy;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_mag  <= '0;
      r_cnt  <= '0;
      r_left <= 1'b0;
      r_busy <= 1'b0;
    end else if (i_load) begin
      r_mag  <= MAG_W'(i_sig);
      r_cnt  <= i_cnt;
      r_left <= i_left;
      r_busy <= 1'b1;
    end else if (r_busy) begin
      if (r_cnt != 5'd0) begin
        r_mag <= r_left ? {r_mag[MAG_W-2:0], 1'b0}
                        : {1'b0, r_mag[MAG_W-1:1]};
        r_cnt <= r_cnt - 5'd1;
      end
      // count of 0 still spends one busy cycle
      if (r_cnt <= 5'd1)
        r_busy <= 1'b0;
    end
  end

`ifdef IIR_Y_F2I_ROUND_EN
  logic r_guard;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n)
      r_guard <= 1'b0;
    else if (i_load)
      r_guard <= 1'b0;
    else if (r_busy && r_cnt != 5'd0)
      r_guard <= !r_left && r_mag[0];
  end

  assign o_guard = r_guard;
`else
  assign o_guard = 1'b0;
`endif

  assign o_busy = r_busy;
  assign o_done = (r_cnt <= 5'd1);
  assign o_mag  = r_mag[OUT_W-1:0];

endmodule

// File: rtl/iir_y_f2i.sv
// iir_y_f2i: float32 -> signed OUT_W fixed point, iterative shifter.
// Ports: i_CLK, i_RSTN (async low), bus (slave: Y in, INT out).
// Macro IIR_Y_F2I_ROUND_EN: round half away from zero instead of truncate.
module iir_y_f2i
  import iir_y_f2i_pkg::*;
#(
  parameter int OUT_W     = 24,
  parameter int FRAC_BITS = 0
) (
  input logic        i_CLK,
  input logic        i_RSTN,
  iir_y_f2i_if.slave bus
);
  localparam logic [OUT_W-1:0] SAT_POS = {1'b0, {(OUT_W-1){1'b1}}};
  localparam logic [OUT_W-1:0] SAT_NEG = {1'b1, {(OUT_W-1){1'b0}}};

  state_e           r_state;
  f32_t             r_y;
  logic             r_y_ack;
  logic [OUT_W-1:0] r_int_data;
  logic             r_int_valid;

  logic [9:0]       w_e;
  logic             w_zero;
  logic             w_sat;
  logic             w_left;
  logic [4:0]       w_dist;
  logic             w_load;
  logic             w_busy;
  logic             w_done;
  logic             w_guard;
  logic [OUT_W-1:0] w_mag;
  logic [OUT_W-1:0] w_sat_val;
  logic [OUT_W:0]   w_rnd;
  logic [OUT_W-1:0] w_res;

  // two's-complement e; bit 9 is the sign
  assign w_e = 10'(r_y.exp) - 10'(EXP_BIAS) + 10'(FRAC_BITS);

  always_comb begin
    w_zero = 1'b0;
    w_sat  = 1'b0;
    if (r_y.exp == 8'd0 ||
        (r_y.exp == EXP_SPECIAL && r_y.frac != '0) ||
        w_e[9])
      w_zero = 1'b1;
    else if (r_y.exp == EXP_SPECIAL ||
             w_e >= 10'(OUT_W-1))
      w_sat = 1'b1;
  end

  assign w_left = !w_e[9] && (w_e > 10'd23);
  assign w_dist = w_left ? 5'(w_e - 10'd23)
                         : 5'(10'd23 - w_e);
  assign w_load = (r_state == ST_DECODE) &&
                  !w_zero && !w_sat;

  assign w_sat_val = r_y.s ? SAT_NEG : SAT_POS;
  assign w_rnd     = {1'b0, w_mag} +
                     {{OUT_W{1'b0}}, w_guard};

  // rounding up to 2^(OUT_W-1) clips to the sign's limit
  always_comb begin
    w_res = w_sat_val;
    if (w_rnd[OUT_W:OUT_W-1] == 2'b00)
      w_res = r_y.s ? -w_rnd[OUT_W-1:0]
                    : w_rnd[OUT_W-1:0];
  end

  f2i_shifter #(
    .OUT_W (OUT_W)
  ) u_shifter (
    .i_clk   (i_CLK),
    .i_rst_n (i_RSTN),
    .i_load  (w_load),
    .i_sig   ({1'b1, r_y.frac}),
    .i_cnt   (w_dist),
    .i_left  (w_left),
    .o_busy  (w_busy),
    .o_done  (w_done),
    .o_mag   (w_mag),
    .o_guard (w_guard)
  );

  always_ff @(posedge i_CLK or negedge i_RSTN) begin
    if (!i_RSTN) begin
      r_state     <= ST_IDLE;
      r_y         <= '0;
      r_y_ack     <= 1'b0;
      r_int_data  <= '0;
      r_int_valid <= 1'b0;
    end else begin
      r_y_ack <= 1'b0;
      unique case (r_state)
        ST_IDLE: begin
          if (bus.i_Y_DATA_VALID && !r_y_ack) begin
            r_y     <= bus.i_Y_DATA;
            r_y_ack <= 1'b1;
            r_state <= ST_DECODE;
          end
        end
        ST_DECODE: begin
          if (w_zero) begin
            r_int_data <= '0;
            r_state    <= ST_FINISH;
          end else if (w_sat) begin
            r_int_data <= w_sat_val;
            r_state    <= ST_FINISH;
          end else begin
            r_state <= ST_SHIFT;
          end
        end
        ST_SHIFT: begin
          if (w_busy && w_done)
            r_state <= ST_SIGN;
        end
        ST_SIGN: begin
          r_int_data <= w_res;
          r_state    <= ST_FINISH;
        end
        ST_FINISH: begin
          if (!r_int_valid) begin
            r_int_valid <= 1'b1;
          end else if (bus.i_INT_ACK) begin
            r_int_valid <= 1'b0;
            r_state     <= ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign bus.o_Y_ACK          = r_y_ack;
  assign bus.o_INT_DATA       = r_int_data;
  assign bus.o_INT_DATA_VALID = r_int_valid;

endmodule

// File: tb/tb_iir_y_f2i.sv
// tb_iir_y_f2i: directed vectors for iir_y_f2i (FRAC_BITS 0 and 4).
// Checks values, latency, ack pulse, stall hold and async reset.
module tb_iir_y_f2i;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   n_cmp = 0;
  int   n_err = 0;
  int   acks;
  bit   stable;
  bit   seen;
  int   k;

`ifdef IIR_Y_F2I_ROUND_EN
  localparam logic [31:0] E_M25 = 32'h00FF_FFFD;
  localparam logic [31:0] E_15  = 32'h0000_0002;
`else
  localparam logic [31:0] E_M25 = 32'h00FF_FFFE;
  localparam logic [31:0] E_15  = 32'h0000_0001;
`endif

  iir_y_f2i_if #(.OUT_W(24)) if0 ();
  iir_y_f2i_if #(.OUT_W(24)) if1 ();

  iir_y_f2i #(
    .OUT_W     (24),
    .FRAC_BITS (0)
  ) u_dut (
    .i_CLK  (clk),
    .i_RSTN (rst_n),
    .bus    (if0)
  );

  iir_y_f2i #(
    .OUT_W     (24),
    .FRAC_BITS (4)
  ) u_dut4 (
    .i_CLK  (clk),
    .i_RSTN (rst_n),
    .bus    (if1)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h", tag, got, exp);
    end
  endtask

  task automatic drv(input bit sel, input logic [31:0] d,
                     input logic v);
    if (sel) begin
      if1.i_Y_DATA       = d;
      if1.i_Y_DATA_VALID = v;
    end else begin
      if0.i_Y_DATA       = d;
      if0.i_Y_DATA_VALID = v;
    end
  endtask

  task automatic set_valid(input bit sel, input logic v);
    if (sel) if1.i_Y_DATA_VALID = v;
    else     if0.i_Y_DATA_VALID = v;
  endtask

  task automatic set_ack(input bit sel, input logic a);
    if (sel) if1.i_INT_ACK = a;
    else     if0.i_INT_ACK = a;
  endtask

  function automatic logic rd_yack(input bit sel);
    return sel ? if1.o_Y_ACK : if0.o_Y_ACK;
  endfunction

  function automatic logic rd_valid(input bit sel);
    return sel ? if1.o_INT_DATA_VALID : if0.o_INT_DATA_VALID;
  endfunction

  function automatic logic [31:0] rd_data(input bit sel);
    return sel ? 32'(if1.o_INT_DATA) : 32'(if0.o_INT_DATA);
  endfunction

  task automatic wait_result(input bit sel,
                             input logic [31:0] exp_data,
                             input int exp_lat,
                             input string tag,
                             input bit do_ack);
    bit   s_ack;
    bit   got;
    int   i;
    int   n;
    logic a1;
    s_ack = 0;
    i = 0;
    while (!s_ack && i < 10) begin
      @(negedge clk);
      i++;
      s_ack = rd_yack(sel);
    end
    check({tag, "_ack"}, 32'(s_ack), 32'd1);
    set_valid(sel, 1'b0);
    n = 0;
    got = 0;
    a1 = 1'b1;
    while (!got && n < 100) begin
      @(negedge clk);
      n++;
      if (n == 1) a1 = rd_yack(sel);
      got = rd_valid(sel);
    end
    check({tag, "_pulse"}, 32'(a1), 32'd0);
    check({tag, "_lat"}, 32'(n), 32'(exp_lat));
    check({tag, "_data"}, rd_data(sel), exp_data);
    if (do_ack) begin
      set_ack(sel, 1'b1);
      @(negedge clk);
      set_ack(sel, 1'b0);
      check({tag, "_drop"}, 32'(rd_valid(sel)), 32'd0);
    end
  endtask

  task automatic convert(input bit sel, input logic [31:0] x,
                         input logic [31:0] exp_data,
                         input int exp_lat, input string tag,
                         input bit do_ack);
    drv(sel, x, 1'b1);
    wait_result(sel, exp_data, exp_lat, tag, do_ack);
  endtask

  initial begin
    drv(1'b0, 32'h0, 1'b0);
    drv(1'b1, 32'h0, 1'b0);
    set_ack(1'b0, 1'b0);
    set_ack(1'b1, 1'b0);
    repeat (3) @(negedge clk);
    check("rst_yack", 32'(rd_yack(1'b0)), 32'd0);
    check("rst_data", rd_data(1'b0), 32'd0);
    check("rst_valid", 32'(rd_valid(1'b0)), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    convert(1'b1, 32'h3FC00000, 32'h18, 22, "f4_1p5", 1'b1);
    convert(1'b0, 32'h3F800000, 32'h1, 26, "one", 1'b1);
    convert(1'b0, 32'hC0200000, E_M25, 25, "m2p5", 1'b1);
    convert(1'b0, 32'h3FC00000, E_15, 26, "1p5", 1'b1);
    convert(1'b0, 32'h4A800000, 32'h400000, 4, "2p22", 1'b1);
    convert(1'b0, 32'h4B000000, 32'h7FFFFF, 2, "2p23", 1'b1);
    convert(1'b0, 32'hFF800000, 32'h800000, 2, "ninf", 1'b1);
    convert(1'b0, 32'h7FC00000, 32'h0, 2, "nan", 1'b1);
    convert(1'b0, 32'h00000000, 32'h0, 2, "zero", 1'b1);
    convert(1'b0, 32'h3E800000, 32'h0, 2, "q25", 1'b1);

    convert(1'b0, 32'hC0200000, E_M25, 25, "stall", 1'b0);
    drv(1'b0, 32'h41200000, 1'b1);
    stable = 1;
    acks = 0;
    repeat (50) begin
      @(negedge clk);
      if (rd_yack(1'b0)) acks++;
      if (rd_data(1'b0) !== E_M25 || !rd_valid(1'b0))
        stable = 0;
    end
    check("stall_stable", 32'(stable), 32'd1);
    check("stall_noack", 32'(acks), 32'd0);
    set_ack(1'b0, 1'b1);
    @(negedge clk);
    set_ack(1'b0, 1'b0);
    wait_result(1'b0, 32'hA, 23, "after", 1'b1);

    drv(1'b0, 32'h3F800000, 1'b1);
    seen = 0;
    k = 0;
    while (!seen && k < 10) begin
      @(negedge clk);
      k++;
      seen = rd_yack(1'b0);
    end
    check("rstrun_ack", 32'(seen), 32'd1);
    set_valid(1'b0, 1'b0);
    repeat (5) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("arst_data", rd_data(1'b0), 32'd0);
    check("arst_valid", 32'(rd_valid(1'b0)), 32'd0);
    check("arst_yack", 32'(rd_yack(1'b0)), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    stable = 1;
    repeat (40) begin
      @(negedge clk);
      if (rd_valid(1'b0) || rd_yack(1'b0)) stable = 0;
    end
    check("rst_discard", 32'(stable), 32'd1);
    convert(1'b0, 32'h41200000, 32'hA, 23, "ten", 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_err);
    $finish;
  end

endmodule
